shift_line_window: RTL and testbench
====================================

# shift_line_window

Streaming line-buffer window generator for the edge-detector datapath. Pixel words enter one per accepted write. The block presents a 2x2 neighbourhood: the two newest words of the current line, and the two words exactly one line earlier. It combines a 2-word input shift stage, a RAM-based line delay, and a 2-word output shift stage. It sits between the pixel source and the edge-detection arithmetic.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of each pixel word.
- `LINE_LEN`, 76: words per image line, i.e. the delay between the current-line and previous-line window rows; minimum 4.
- `ADDR_WIDTH`, 7: line-delay RAM pointer width; must satisfy 2^ADDR_WIDTH >= LINE_LEN.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `write_en` in 1: accept `data_in` and advance the whole pipeline this cycle.
- `data_in` in DATA_WIDTH: incoming pixel word.
- `word_1` out DATA_WIDTH: newest word, current line (w5).
- `word_2` out DATA_WIDTH: previous word, current line (w4).
- `word_3` out DATA_WIDTH: word one line earlier than `word_1` (w3).
- `word_4` out DATA_WIDTH: word one line earlier than `word_2` (w2).
- `line_out` out DATA_WIDTH: equals `word_4`; cascade output for chaining a further line stage.
- `ready` out 1: window fully primed; `word_4` holds real data.

## Operation
- Number accepted inputs x_1, x_2, … from reset. An input is accepted on each rising edge with `write_en`=1. Any x_j with j<1 reads as 0.
- After accepted write k, the outputs are: `word_1`=x_k, `word_2`=x_(k-1), `word_3`=x_(k-LINE_LEN), `word_4`=x_(k-LINE_LEN-1).
- Structure:
  - Input stage: 2 registers (x_k, x_(k-1)).
  - Line delay: RAM of LINE_LEN-2 entries with read-before-write at a single internal circular pointer. The pointer increments per accepted write and wraps from LINE_LEN-3 to 0. The RAM takes its input from the older input register.
  - Output stage: 2 registers fed by the RAM read data.
- The address pointer is internal; no external address port.
- RAM contents are not reset. A fill counter gates the previous-line outputs, so `word_3`/`word_4` show 0 until the corresponding sample exists.
- The fill counter saturates at LINE_LEN+1.
- `ready` = fill counter reached LINE_LEN+1. It stays high until reset.
- `write_en`=0: pointer, registers, counter and all outputs hold; no RAM write.
- Arithmetic: the pointer is modulo LINE_LEN-2. No data arithmetic; words pass bit-exact.

## Timing
- All outputs are registered and update on the rising edge that accepts a write. They are valid in the following cycle.
- Latency:
  - `data_in` to `word_1`: 1 accepted write.
  - `data_in` to `word_3`: LINE_LEN accepted writes.
  - `data_in` to `word_4`: LINE_LEN+1 accepted writes.
- `ready` rises on the edge of accepted write LINE_LEN+1 (77 by default).
- Back-to-back writes are sustained every cycle; no stall or backpressure output.
- Stalls of any length are lossless. Delay is counted in accepted writes, not cycles.
- Reset (`rst_n`=0, at any time including mid-line): immediately drives all outputs to 0, `ready` to 0, pointer and fill counter to 0.
  - While held low, the block ignores `write_en`.
  - After release, the first accepted write is x_1 again.
  - Stale RAM data never appears on the outputs.

## Test plan
- Reset: assert `rst_n`=0 asynchronously between edges. All `word_*`, `line_out` and `ready` go to 0 without waiting for a clock edge.
- Continuous stream `data_in`=1,2,3,… with `write_en`=1 every cycle:
  - After write 5: `word_1`=5, `word_2`=4, `word_3`=0, `word_4`=0, `ready`=0.
  - After write 77: `word_3`=1, `word_4`=0, `ready`=1.
  - After write 78: `word_3`=2, `word_4`=1.
- Stall: drop `write_en` for 22 cycles after write 100. All outputs hold (`word_1`=100, `word_3`=24). On resume, write 101 gives `word_1`=101, `word_3`=25.
- Wrap: stream 500 writes. After every write k>77, `word_3`=k-76 and `word_4`=k-77, across repeated pointer wraps.
- Mid-stream reset: pulse `rst_n` low after write 150. Outputs go to 0. Restarting the stream at 1 reproduces the priming sequence exactly, with `ready` low until write 77 and no stale previous-line words.
- Parameter check: with `LINE_LEN`=8 and `ADDR_WIDTH`=3, after write k≥10, `word_3`=k-8 and `word_4`=k-9; `ready` rises at write 9.

Source files
------------

// File: rtl/shift_line_window_if.sv
// shift_line_window_if: pixel write port and 2x2 window outputs of the line-window block
interface shift_line_window_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  write_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] word_1;
  logic [DATA_WIDTH-1:0] word_2;
  logic [DATA_WIDTH-1:0] word_3;
  logic [DATA_WIDTH-1:0] word_4;
  logic [DATA_WIDTH-1:0] line_out;
  logic                  ready;
  modport master (
    output write_en, data_in,
    input  word_1, word_2, word_3, word_4, line_out, ready
  );
  modport slave (
    input  write_en, data_in,
    output word_1, word_2, word_3, word_4, line_out, ready
  );
endinterface

// File: rtl/shift_line_window.sv
// shift_line_window: 2x2 window over the current and previous image line via a RAM line delay
module shift_line_window #(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_LEN   = 76,
  parameter int ADDR_WIDTH = 7
) (
  input logic               clk,
  input logic               rst_n,
  shift_line_window_if.slave bus
);
  localparam int RAM_DEPTH = LINE_LEN - 2;
  localparam int CNT_WIDTH = $clog2(LINE_LEN + 2);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST   = ADDR_WIDTH'(LINE_LEN - 3);
  localparam logic [CNT_WIDTH-1:0]  CNT_PRIMED = CNT_WIDTH'(LINE_LEN);
  localparam logic [CNT_WIDTH-1:0]  CNT_FULL   = CNT_WIDTH'(LINE_LEN + 1);
  logic [DATA_WIDTH-1:0] ram [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] cur, prev, up, up_prev, rd;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  ready;
  logic                  adv;
  // Read-before-write: the slot at ptr still holds the word written LINE_LEN-2 writes ago
  assign rd  = ram[ptr];
  assign adv = bus.write_en && rst_n;
  // Line delay storage; not reset, stale contents are masked by the fill gate
  always_ff @(posedge clk) begin
    if (adv) ram[ptr] <= prev;
  end
  // Input shift, output shift, circular pointer and fill counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     <= '0;
      prev    <= '0;
      up      <= '0;
      up_prev <= '0;
      ptr     <= '0;
      cnt     <= '0;
      ready   <= 1'b0;
    end else if (bus.write_en) begin
      cur     <= bus.data_in;
      prev    <= cur;
      up      <= (cnt >= CNT_PRIMED) ? rd : '0;
      up_prev <= up;
      ptr     <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
      cnt     <= (cnt == CNT_FULL) ? cnt : cnt + 1'b1;
      ready   <= ready || (cnt >= CNT_PRIMED);
    end
  end
  assign bus.word_1   = cur;
  assign bus.word_2   = prev;
  assign bus.word_3   = up;
  assign bus.word_4   = up_prev;
  assign bus.line_out = up_prev;
  assign bus.ready    = ready;
endmodule

// File: tb/tb_shift_line_window.sv
// tb_shift_line_window: random and directed streams against a history-array model, two line lengths
module tb_shift_line_window;
  localparam int DW = 32;
  localparam int LA = 76;
  localparam int LB = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  shift_line_window_if #(.DATA_WIDTH(DW)) bus_a ();
  shift_line_window_if #(.DATA_WIDTH(DW)) bus_b ();
  shift_line_window #(.DATA_WIDTH(DW), .LINE_LEN(LA), .ADDR_WIDTH(7)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  shift_line_window #(.DATA_WIDTH(DW), .LINE_LEN(LB), .ADDR_WIDTH(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  int tests = 0;
  int fails = 0;
  logic [DW-1:0] hist [$];
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] x(input int j);
    return (j < 1 || j > hist.size()) ? '0 : hist[j-1];
  endfunction
  task automatic check_all();
    int k;
    k = hist.size();
    check($sformatf("a.word_1@%0d", k), bus_a.word_1, x(k));
    check($sformatf("a.word_2@%0d", k), bus_a.word_2, x(k-1));
    check($sformatf("a.word_3@%0d", k), bus_a.word_3, x(k-LA));
    check($sformatf("a.word_4@%0d", k), bus_a.word_4, x(k-LA-1));
    check($sformatf("a.line_out@%0d", k), bus_a.line_out, x(k-LA-1));
    check($sformatf("a.ready@%0d", k), DW'(bus_a.ready), DW'(k >= LA+1));
    check($sformatf("b.word_1@%0d", k), bus_b.word_1, x(k));
    check($sformatf("b.word_2@%0d", k), bus_b.word_2, x(k-1));
    check($sformatf("b.word_3@%0d", k), bus_b.word_3, x(k-LB));
    check($sformatf("b.word_4@%0d", k), bus_b.word_4, x(k-LB-1));
    check($sformatf("b.line_out@%0d", k), bus_b.line_out, x(k-LB-1));
    check($sformatf("b.ready@%0d", k), DW'(bus_b.ready), DW'(k >= LB+1));
  endtask
  task automatic step(input logic en, input logic [DW-1:0] d);
    bus_a.write_en = en;
    bus_a.data_in  = d;
    bus_b.write_en = en;
    bus_b.data_in  = d;
    @(posedge clk);
    if (en && rst_n) hist.push_back(d);
    #1 check_all();
  endtask
  initial begin
    bus_a.write_en = 1'b1;
    bus_a.data_in  = 32'h1234;
    bus_b.write_en = 1'b1;
    bus_b.data_in  = 32'h1234;
    #12 check_all();
    @(negedge clk) rst_n = 1'b1;
    for (int k = 1; k <= 150; k++) begin
      step(1'b1, DW'(k));
      if (k == 100) repeat (22) step(1'b0, $urandom);
    end
    #2 rst_n = 1'b0;
    hist.delete();
    #1 check_all();
    step(1'b1, 32'hdead_beef);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 1; k <= 500; k++) step(1'b1, DW'(k));
    repeat (600) step($urandom_range(0, 3) != 0, $urandom);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
